// File: rtl/sdram_read_arb.sv
// Round-robin arbiter for the shared SDRAM read port: grants one requester, counts its beats, releases after a 1-cycle gap.
// Optional idle-beat watchdog enabled by defining SDRAM_READ_ARB_TIMEOUT_EN.
module sdram_read_arb #(
  parameter int N           = 4,
  parameter int SEL_W       = 5,
  parameter int LEN_W       = 11,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*LEN_W-1:0] req_len,
  input  logic               rd_valid,
  output logic [N-1:0]       grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic [N-1:0]       done,
  output logic               timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   beat_cnt;
  logic [LEN_W:0]   last_beat;
  logic             pick_vld;
  logic [SEL_W-1:0] pick_idx;
  logic [LEN_W-1:0] pick_len;
  logic [SEL_W-1:0] next_ptr;

  // A latched length of zero encodes a full 2^LEN_W-beat burst.
  assign last_beat = {len_q == '0, len_q} - {{LEN_W{1'b0}}, 1'b1};
  assign next_ptr  = (int'(sel) == N - 1) ? '0 : sel + SEL_W'(1);

  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_len = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick_idx = SEL_W'(j);
        pick_len = req_len[j*LEN_W +: LEN_W];
      end
    end
  end

`ifdef SDRAM_READ_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  // No watchdog in this build; the port is held low.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      done     <= '0;
      rr_ptr   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
`ifdef SDRAM_READ_ARB_TIMEOUT_EN
      timeout  <= 1'b0;
      wd_cnt   <= '0;
`endif
    end else begin
      done <= '0;
`ifdef SDRAM_READ_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant    <= N'(1) << pick_idx;
            sel      <= pick_idx;
            busy     <= 1'b1;
            len_q    <= pick_len;
            beat_cnt <= '0;
`ifdef SDRAM_READ_ARB_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (rd_valid) begin
`ifdef SDRAM_READ_ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            if (beat_cnt == last_beat) begin
              done   <= grant;
              grant  <= '0;
              sel    <= '0;
              busy   <= 1'b0;
              rr_ptr <= next_ptr;
              state  <= GAP;
            end else begin
              beat_cnt <= beat_cnt + {{LEN_W{1'b0}}, 1'b1};
            end
          end
`ifdef SDRAM_READ_ARB_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
            timeout <= 1'b1;
            grant   <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            rr_ptr  <= next_ptr;
            state   <= GAP;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_read_arb.sv
// Directed bench for sdram_read_arb (N=4, LEN_W=3, TIMEOUT_CYC=16); each task checks its own scenario.
module tb_sdram_read_arb;
  localparam int N = 4, SEL_W = 5, LEN_W = 3, TO = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       req = '0;
  logic [N*LEN_W-1:0] req_len = '0;
  logic               rd_valid = 1'b0;
  logic [N-1:0]       grant;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic [N-1:0]       done;
  logic               timeout;
  int total = 0;
  int bad = 0;

  sdram_read_arb #(.N(N), .SEL_W(SEL_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .rd_valid(rd_valid),
    .grant(grant), .sel(sel), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beats(input int n);
    rd_valid = 1'b1;
    repeat (n) tick();
    rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    total++; if (sel !== 5'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", sel); end
    total++; if (busy !== 1'b0 || done !== 4'b0000 || timeout !== 1'b0) begin bad++; $display("FAIL reset_flags: got busy=%b done=%b timeout=%b want 0/0000/0", busy, done, timeout); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0001; req_len[0 +: 3] = 3'd4;
    tick();
    total++; if (grant !== 4'b0001 || sel !== 5'd0 || busy !== 1'b1) begin bad++; $display("FAIL single_grant: got grant=%b sel=%0d busy=%b want 0001/0/1", grant, sel, busy); end
    req = 4'b0000;
    rd_valid = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      tick();
      if (b < 4) begin
        total++; if (done !== 4'b0000 || grant !== 4'b0001) begin bad++; $display("FAIL single_mid beat %0d: got done=%b grant=%b want 0000/0001", b, done, grant); end
      end
    end
    total++; if (done !== 4'b0001 || grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL single_done: got done=%b grant=%b busy=%b want 0001/0000/0", done, grant, busy); end
    rd_valid = 1'b0;
    req = 4'b0001;
    tick();
    total++; if (grant !== 4'b0000 || done !== 4'b0000) begin bad++; $display("FAIL single_gap: got grant=%b done=%b want 0000/0000", grant, done); end
    tick();
    total++; if (grant !== 4'b0001 || sel !== 5'd0) begin bad++; $display("FAIL single_regrant: got grant=%b sel=%0d want 0001/0", grant, sel); end
    req = 4'b0000;
    beats(4);
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL single_done2: got %b want 0001", done); end
    tick();
  endtask

  task automatic test_alternate();
    logic [3:0] exp_g [3];
    int         exp_s [3];
    exp_g = '{4'b0010, 4'b1000, 4'b0010};
    exp_s = '{1, 3, 1};
    req = 4'b1010; req_len = {3'd2, 3'd2, 3'd2, 3'd2};
    rd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (grant !== exp_g[i] || int'(sel) != exp_s[i] || busy !== 1'b1) begin bad++; $display("FAIL alt_grant %0d: got grant=%b sel=%0d want %b/%0d", i, grant, sel, exp_g[i], exp_s[i]); end
      if (i == 2) req = 4'b0000;
      tick();
      tick();
      total++; if (done !== exp_g[i] || grant !== 4'b0000) begin bad++; $display("FAIL alt_done %0d: got done=%b grant=%b want %b/0000", i, done, grant, exp_g[i]); end
      tick();
    end
    rd_valid = 1'b0;
  endtask

  task automatic test_zero_len();
    req = 4'b0100; req_len = '0;
    tick();
    total++; if (grant !== 4'b0100 || sel !== 5'd2) begin bad++; $display("FAIL zlen_grant: got grant=%b sel=%0d want 0100/2", grant, sel); end
    req = 4'b0000;
    rd_valid = 1'b1;
    for (int b = 1; b <= 8; b++) begin
      tick();
      if (b < 8) begin
        total++; if (grant !== 4'b0100 || done !== 4'b0000) begin bad++; $display("FAIL zlen_hold beat %0d: got grant=%b done=%b want 0100/0000", b, grant, done); end
      end
    end
    total++; if (done !== 4'b0100 || busy !== 1'b0) begin bad++; $display("FAIL zlen_done: got done=%b busy=%b want 0100/0", done, busy); end
    rd_valid = 1'b0;
    tick();
  endtask

  task automatic test_idle_beats();
    rd_valid = 1'b1;
    repeat (3) tick();
    total++; if (busy !== 1'b0 || done !== 4'b0000 || grant !== 4'b0000) begin bad++; $display("FAIL idle_beats: got busy=%b done=%b grant=%b want 0/0000/0000", busy, done, grant); end
    rd_valid = 1'b0;
    req = 4'b0001; req_len[0 +: 3] = 3'd3;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL idle_grant: got %b want 0001", grant); end
    req = 4'b0000;
    rd_valid = 1'b1;
    tick();
    tick();
    total++; if (done !== 4'b0000 || grant !== 4'b0001) begin bad++; $display("FAIL idle_early: got done=%b grant=%b want 0000/0001", done, grant); end
    tick();
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL idle_done: got %b want 0001", done); end
    rd_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b0001; req_len[0 +: 3] = 3'd5;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rmid_grant: got %b want 0001", grant); end
    req = 4'b0000;
    beats(2);
    #2 rst_n = 1'b0;
    #1;
    total++; if (grant !== 4'b0000 || sel !== 5'd0 || busy !== 1'b0 || done !== 4'b0000) begin bad++; $display("FAIL rmid_async: got grant=%b sel=%0d busy=%b done=%b want all 0", grant, sel, busy, done); end
    tick();
    rst_n = 1'b1;
    req = 4'b0011; req_len[0 +: 3] = 3'd2; req_len[3 +: 3] = 3'd2;
    tick();
    total++; if (grant !== 4'b0001 || sel !== 5'd0) begin bad++; $display("FAIL rmid_ptr: got grant=%b sel=%0d want 0001/0", grant, sel); end
    req = 4'b0000;
    beats(2);
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL rmid_done: got %b want 0001", done); end
    tick();
  endtask

  task automatic test_timeout();
    req = 4'b0110; req_len[3 +: 3] = 3'd4; req_len[6 +: 3] = 3'd2;
    tick();
    total++; if (grant !== 4'b0010 || sel !== 5'd1) begin bad++; $display("FAIL to_grant: got grant=%b sel=%0d want 0010/1", grant, sel); end
    req = 4'b0100;
    beats(1);
`ifdef SDRAM_READ_ARB_TIMEOUT_EN
    for (int c = 1; c < TO; c++) begin
      tick();
      total++; if (timeout !== 1'b0 || grant !== 4'b0010) begin bad++; $display("FAIL to_wait %0d: got timeout=%b grant=%b want 0/0010", c, timeout, grant); end
    end
    tick();
    total++; if (timeout !== 1'b1 || grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL to_pulse: got timeout=%b grant=%b done=%b busy=%b want 1/0000/0000/0", timeout, grant, done, busy); end
    tick();
    total++; if (timeout !== 1'b0 || grant !== 4'b0000) begin bad++; $display("FAIL to_gap: got timeout=%b grant=%b want 0/0000", timeout, grant); end
    tick();
`else
    for (int c = 1; c <= TO + 2; c++) begin
      tick();
      total++; if (timeout !== 1'b0 || grant !== 4'b0010 || busy !== 1'b1) begin bad++; $display("FAIL to_hold %0d: got timeout=%b grant=%b busy=%b want 0/0010/1", c, timeout, grant, busy); end
    end
    beats(3);
    total++; if (done !== 4'b0010) begin bad++; $display("FAIL to_finish: got %b want 0010", done); end
    tick();
    tick();
`endif
    total++; if (grant !== 4'b0100 || sel !== 5'd2) begin bad++; $display("FAIL to_next: got grant=%b sel=%0d want 0100/2", grant, sel); end
    req = 4'b0000;
    beats(2);
    total++; if (done !== 4'b0100) begin bad++; $display("FAIL to_next_done: got %b want 0100", done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_zero_len();
    test_idle_beats();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
